// File: rtl/falco_store_buffer.sv
// falco_store_buffer: in-order store buffer between the core store port and memory.
//
// Holds up to DEPTH word stores and drains them oldest-first, one per memory
// handshake. A combinational lookup returns the youngest buffered store that
// matches a load's word address, so loads observe stores still in the buffer.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   st_valid/st_ready          core store handshake (st_addr, st_data, st_be)
//   mem_valid/mem_ready        memory store handshake (mem_addr, mem_data, mem_be)
//   ld_check, ld_addr          load lookup request
//   fwd_hit, fwd_data, fwd_be  forwarding result from the youngest matching entry
//   count, empty, full         occupancy status
module falco_store_buffer #(
  parameter int unsigned XLEN_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [XLEN_WIDTH-1:0]   st_addr,
  input  logic [XLEN_WIDTH-1:0]   st_data,
  input  logic [XLEN_WIDTH/8-1:0] st_be,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [XLEN_WIDTH-1:0]   mem_addr,
  output logic [XLEN_WIDTH-1:0]   mem_data,
  output logic [XLEN_WIDTH/8-1:0] mem_be,
  input  logic                    ld_check,
  input  logic [XLEN_WIDTH-1:0]   ld_addr,
  output logic                    fwd_hit,
  output logic [XLEN_WIDTH-1:0]   fwd_data,
  output logic [XLEN_WIDTH/8-1:0] fwd_be,
  output logic [CNT_W-1:0]        count,
  output logic                    empty,
  output logic                    full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned BeW  = XLEN_WIDTH / 8;

  logic [XLEN_WIDTH-1:0] addr_q [DEPTH];
  logic [XLEN_WIDTH-1:0] data_q [DEPTH];
  logic [BeW-1:0]        be_q   [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PtrW-1:0]       head_q;
  logic [PtrW-1:0]       tail_q;
  logic [CNT_W-1:0]      count_q;

  logic enq;
  logic deq;

  // Byte offset within the word plays no part in the match.
  logic unused_ld_bits;
  assign unused_ld_bits = ^ld_addr[1:0];

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  // Only registered occupancy: a dequeue in the same cycle never frees a slot.
  assign st_ready  = !full;
  assign mem_valid = !empty;
  assign mem_addr  = addr_q[head_q];
  assign mem_data  = data_q[head_q];
  assign mem_be    = be_q[head_q];

  assign enq = st_valid && st_ready;
  assign deq = mem_valid && mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      // Storage is cleared so idle mem_*/fwd_* outputs read as zero.
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      if (enq) begin
        addr_q[tail_q]  <= st_addr;
        data_q[tail_q]  <= st_data;
        be_q[tail_q]    <= st_be;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PtrW'(1);
      end
      if (deq) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrW'(1);
      end
      if (enq && !deq) begin
        count_q <= count_q + CNT_W'(1);
      end else if (deq && !enq) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Walk entries oldest to youngest from head; the last match seen is the youngest.
  logic            match_any;
  logic [PtrW-1:0] idx;

  always_comb begin
    match_any = 1'b0;
    fwd_data  = '0;
    fwd_be    = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + i[PtrW-1:0];
      if (valid_q[idx] && (addr_q[idx][XLEN_WIDTH-1:2] == ld_addr[XLEN_WIDTH-1:2])) begin
        match_any = 1'b1;
        fwd_data  = data_q[idx];
        fwd_be    = be_q[idx];
      end
    end
  end

  assign fwd_hit = ld_check && match_any;

endmodule

// File: tb/tb_falco_store_buffer.sv
// Self-checking bench for falco_store_buffer. A queue-based reference model of the
// buffer contents is advanced once per cycle; a negedge monitor compares status,
// head presentation and forwarding against it, popping on each memory handshake.
module tb_falco_store_buffer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             st_valid;
  logic             st_ready;
  logic [XLEN-1:0]  st_addr;
  logic [XLEN-1:0]  st_data;
  logic [3:0]       st_be;
  logic             mem_valid;
  logic             mem_ready;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_data;
  logic [3:0]       mem_be;
  logic             ld_check;
  logic [XLEN-1:0]  ld_addr;
  logic             fwd_hit;
  logic [XLEN-1:0]  fwd_data;
  logic [3:0]       fwd_be;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;

  falco_store_buffer #(
    .XLEN_WIDTH(XLEN),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_be    (st_be),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_be   (mem_be),
    .ld_check (ld_check),
    .ld_addr  (ld_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .fwd_be   (fwd_be),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [3:0]      be;
  } ent_t;

  ent_t model[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   drained     = 0;
  bit   armed       = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard. Inputs are stable here and apply at the next rising edge.
  int   n;
  bit   hit;
  ent_t fe;
  ent_t ne;
  always @(negedge clk) begin
    n = model.size();
    if (!rst && armed) begin
      chk("count", 32'(count), n);
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("st_ready", 32'(st_ready), 32'(n < DEPTH));
      chk("mem_valid", 32'(mem_valid), 32'(n > 0));
      if (n > 0) begin
        chk("mem_addr", mem_addr, model[0].addr);
        chk("mem_data", mem_data, model[0].data);
        chk("mem_be", 32'(mem_be), 32'(model[0].be));
      end
      hit = 1'b0;
      fe  = '0;
      for (int i = 0; i < n; i++) begin
        if (model[i].addr[XLEN-1:2] == ld_addr[XLEN-1:2]) begin
          hit = 1'b1;
          fe  = model[i];
        end
      end
      chk("fwd_hit", 32'(fwd_hit), 32'(ld_check && hit));
      if (ld_check && hit) begin
        chk("fwd_data", fwd_data, fe.data);
        chk("fwd_be", 32'(fwd_be), 32'(fe.be));
      end
    end
    if (rst) begin
      model.delete();
      armed = 1'b1;
    end else if (armed) begin
      if (n > 0 && mem_ready) begin
        void'(model.pop_front());
        drained++;
      end
      if (st_valid && n < DEPTH) begin
        ne.addr = st_addr;
        ne.data = st_data;
        ne.be   = st_be;
        model.push_back(ne);
      end
    end
  end

  task automatic drive(input logic sv, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic mr, input logic lc,
                       input logic [31:0] la, input logic r);
    st_valid  = sv;
    st_addr   = a;
    st_data   = d;
    st_be     = b;
    mem_ready = mr;
    ld_check  = lc;
    ld_addr   = la;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic mr, input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 32'h0, 32'h0, 4'h0, mr, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                       input logic mr);
    drive(1'b1, a, d, b, mr, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic load(input logic [31:0] la);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, la, 1'b0);
  endtask

  int drained_before;

  initial begin
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(1'b0, 2);

    // Single store held under stall, then one handshake.
    store(32'h100, 32'hAABBCCDD, 4'hF, 1'b0);
    idle(1'b0, 5);
    idle(1'b1, 1);
    idle(1'b0, 2);

    // Fill to full, rejected 5th store, single-cycle drain.
    store(32'h0, 32'h0000_0001, 4'hF, 1'b0);
    store(32'h4, 32'h0000_0002, 4'hF, 1'b0);
    store(32'h8, 32'h0000_0003, 4'hF, 1'b0);
    store(32'hC, 32'h0000_0004, 4'hF, 1'b0);
    store(32'h10, 32'h0000_0005, 4'hF, 1'b0);
    store(32'h10, 32'h0000_0005, 4'hF, 1'b0);
    idle(1'b1, 1);
    idle(1'b0, 1);
    idle(1'b1, 4);

    // Forwarding: youngest match within a word, miss on the next word.
    store(32'h200, 32'h11111111, 4'h1, 1'b0);
    store(32'h202, 32'h22220000, 4'hC, 1'b0);
    load(32'h203);
    load(32'h204);
    load(32'h200);
    idle(1'b1, 3);

    // Streaming with memory always ready.
    drained_before = drained;
    for (int i = 0; i < 10; i++) store(32'h300 + 32'(i * 4), 32'(i) * 32'h01010101, 4'hF, 1'b1);
    idle(1'b1, 2);
    chk("stream_drained", 32'(drained - drained_before), 32'd10);

    // Reset while the head is being accepted discards everything.
    store(32'h400, 32'hDEAD0001, 4'hF, 1'b0);
    store(32'h404, 32'hDEAD0002, 4'hF, 1'b0);
    store(32'h408, 32'hDEAD0003, 4'hF, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    idle(1'b1, 3);
    store(32'h500, 32'hCAFEF00D, 4'h3, 1'b0);
    load(32'h501);
    idle(1'b1, 2);

    // Randomized traffic over a small address window to provoke hits and aliasing.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 60),
            32'h40 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
            $urandom(), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 1) == 1),
            32'h40 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3)),
            ($urandom_range(0, 299) == 0));
    end
    idle(1'b1, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/falco_store_buffer.md
Name: falco_store_buffer

Overview:
- FIFO store buffer between the core store port and the memory model's store interface.
- Accepts word-sized stores from the core, holds up to DEPTH entries, and drains them in order, one per memory handshake.
- Provides combinational store-to-load forwarding, so a load sees the youngest buffered store to the same word.
- Lets the core retire stores without stalling on memory.

Parameters:
- XLEN_WIDTH, 32, data/address width in bits.
- DEPTH, 4, number of buffer entries; must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- st_valid  input  1  core presents a store.
- st_ready  output  1  buffer can accept a store this cycle.
- st_addr  input  XLEN_WIDTH  store byte address.
- st_data  input  XLEN_WIDTH  store data, lane-aligned.
- st_be  input  XLEN_WIDTH/8  byte enables.
- mem_valid  output  1  head entry presented to memory.
- mem_ready  input  1  memory accepts head entry.
- mem_addr  output  XLEN_WIDTH  head address.
- mem_data  output  XLEN_WIDTH  head data.
- mem_be  output  XLEN_WIDTH/8  head byte enables.
- ld_check  input  1  load address lookup valid.
- ld_addr  input  XLEN_WIDTH  load byte address.
- fwd_hit  output  1  a buffered store matches the load word.
- fwd_data  output  XLEN_WIDTH  data of the youngest matching entry.
- fwd_be  output  XLEN_WIDTH/8  byte enables of the youngest matching entry.
- count  output  CNT_W  occupied entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.

Behaviour:
- Storage:
  - Circular array of {addr, data, be} with head/tail pointers of width $clog2(DEPTH) that wrap naturally.
  - Per-entry valid bits plus a registered count.
- Reset:
  - rst=1 at a clock edge clears head, tail, count and all valid bits.
  - Next cycle: mem_valid=0, st_ready=1, empty=1, full=0, count=0, fwd_hit=0.
  - mem_addr/mem_data/mem_be/fwd_data/fwd_be are don't-care while their valid/hit is 0, but must not be X in simulation; drive 0 from cleared storage.
  - Reset mid-drain discards all entries, including one presented with mem_ready=1 in the reset cycle. Memory must not count that as accepted.
- Enqueue:
  - Occurs when st_valid && st_ready; written at tail, tail increments.
  - st_ready = !full. It is registered-state based and never depends on mem_ready.
  - When full, a same-cycle dequeue does not open a slot.
- Dequeue:
  - mem_valid = !empty; mem_* driven from the head entry.
  - On mem_valid && mem_ready, the head is invalidated and head increments.
  - mem_* must hold stable while mem_valid && !mem_ready.
- Latency and count:
  - A store enqueued at edge N is presented on mem_* in the cycle after edge N. There is no same-cycle bypass.
  - Simultaneous enqueue and dequeue leave count unchanged.
  - count never exceeds DEPTH and never underflows.
- Forwarding:
  - Purely combinational.
  - A match requires the entry valid and entry.addr[XLEN_WIDTH-1:2]==ld_addr[XLEN_WIDTH-1:2].
  - fwd_hit = ld_check && any match.
  - fwd_data/fwd_be come from the youngest match, i.e. the one closest to tail going backwards.
  - The head entry stays visible for forwarding until the cycle its handshake completes.
  - Stores enqueued in the current cycle are not visible.
  - No byte merging across entries; the load unit combines fwd_be with memory data.
- Ordering: strict FIFO; addresses never reorder or coalesce.

Test Plan:
- Reset then idle -> count=0, empty=1, st_ready=1, mem_valid=0, fwd_hit=0.
- Enqueue {0x100, 0xAABBCCDD, 0xF} with mem_ready=0 -> mem_valid=1 the next cycle, mem_addr=0x100 held for 5 stall cycles. Raise mem_ready -> one handshake, then empty=1.
- Enqueue 4 stores to 0x0, 0x4, 0x8, 0xC with mem_ready=0 -> full=1, st_ready=0, and a 5th st_valid is not accepted. Pulse mem_ready for 1 cycle -> 0x0 drains, count=3, st_ready=1 next cycle.
- Stores {0x200, 0x11111111, 0x1} then {0x202, 0x22220000, 0xC}. Load check at 0x203 -> fwd_hit=1, fwd_data=0x22220000, fwd_be=0xC. Load check at 0x204 -> fwd_hit=0.
- Hold mem_ready=1 and st_valid=1 with 10 sequential addresses -> count stays 1 in steady state, and the memory sees all 10 in order with no gaps after the first.
- Fill 3 entries, then assert rst for 1 cycle while mem_ready=1 -> no further mem_valid, count=0; the next store is accepted normally.
